// File: rtl/rs232_tx.sv
// rs232_tx: asynchronous serial transmitter. It sends a start bit, LSB-first data,
// an optional parity bit and one stop bit for each word accepted on start_i/ready_o.
module rs232_tx #(
    parameter int Width     = 8,
    parameter int BaudDiv   = 5208,
    parameter bit ParityEn  = 1'b0,
    parameter bit ParityOdd = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [Width-1:0] din_i,
    output logic             tx_o,
    output logic             ready_o,
    output logic             done_tick_o
);

    // state    | meaning
    // S_IDLE   | line high, ready_o high, waiting for start_i
    // S_START  | start bit (line low)
    // S_DATA   | data bits, shift_q[0] on the line, LSB first
    // S_PARITY | parity bit (only reachable when ParityEn)
    // S_STOP   | stop bit (line high); leaving it pulses done_tick_o

    localparam int BW = $clog2(BaudDiv);
    localparam int CW = $clog2(Width) + 1;
    localparam logic [BW-1:0] BaudLast = BW'(BaudDiv - 1);
    localparam logic [BW-1:0] BaudOne  = BW'(1);
    localparam logic [CW-1:0] BitLast  = CW'(Width - 1);
    localparam logic [CW-1:0] BitOne   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e           state_q;
    logic [BW-1:0]    baud_q;
    logic [BW-1:0]    baud_d;
    logic [CW-1:0]    bit_q;
    logic [CW-1:0]    bit_d;
    logic [Width-1:0] shift_q;
    logic [Width-1:0] shift_d;
    logic             parity_q;
    logic             tx_q;
    logic             ready_q;
    logic             done_q;
    logic             baud_wrap;

    always_comb begin
        baud_wrap = (baud_q == BaudLast);
        baud_d    = baud_wrap ? '0 : baud_q + BaudOne;
        bit_d     = bit_q + BitOne;
        shift_d   = shift_q >> 1;
    end

    // All outputs are registered; each one is assigned the value it must show
    // in the cycle after the edge that changes state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    baud_q <= '0;
                    if (start_i) begin
                        shift_q  <= din_i;
                        parity_q <= (^din_i) ^ ParityOdd;
                        state_q  <= S_START;
                        tx_q     <= 1'b0;
                        ready_q  <= 1'b0;
                    end
                end
                S_START: begin
                    baud_q <= baud_d;
                    if (baud_wrap) begin
                        state_q <= S_DATA;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                    end
                end
                S_DATA: begin
                    baud_q <= baud_d;
                    if (baud_wrap) begin
                        shift_q <= shift_d;
                        if (bit_q == BitLast) begin
                            bit_q <= '0;
                            if (ParityEn) begin
                                state_q <= S_PARITY;
                                tx_q    <= parity_q;
                            end else begin
                                state_q <= S_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_q <= bit_d;
                            tx_q  <= shift_d[0];
                        end
                    end
                end
                S_PARITY: begin
                    baud_q <= baud_d;
                    if (baud_wrap) begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                    end
                end
                S_STOP: begin
                    baud_q <= baud_d;
                    if (baud_wrap) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                        tx_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    baud_q  <= '0;
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign tx_o        = tx_q;
    assign ready_o     = ready_q;
    assign done_tick_o = done_q;

endmodule

// File: tb/tb_rs232_tx.sv
// Bench for rs232_tx at BaudDiv=4, Width=8: a loopback receiver checks every frame
// against a queue of expected words; tasks check handshake, timing and parity.
module tb_rs232_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, startp;
    logic [7:0] din0, dinp;
    logic       tx0, ready0, done0;
    logic       tx_pe, ready_pe, done_pe;
    logic       tx_po, ready_po, done_po;

    int         n_cmp = 0;
    int         n_err = 0;
    int         mon_starts = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    rs232_tx #(.Width(8), .BaudDiv(4), .ParityEn(1'b0), .ParityOdd(1'b0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .din_i(din0),
        .tx_o(tx0), .ready_o(ready0), .done_tick_o(done0));

    rs232_tx #(.Width(8), .BaudDiv(4), .ParityEn(1'b1), .ParityOdd(1'b0)) dut_pe (
        .clk_i(clk), .rst_ni(rst_n), .start_i(startp), .din_i(dinp),
        .tx_o(tx_pe), .ready_o(ready_pe), .done_tick_o(done_pe));

    rs232_tx #(.Width(8), .BaudDiv(4), .ParityEn(1'b1), .ParityOdd(1'b1)) dut_po (
        .clk_i(clk), .rst_ni(rst_n), .start_i(startp), .din_i(dinp),
        .tx_o(tx_po), .ready_o(ready_po), .done_tick_o(done_po));

    // Loopback receiver on the main instance: 10 bits x 4 samples, then the done cycle.
    always begin : rx_monitor
        logic [9:0] bits;
        logic [7:0] want;
        bit         steady, aborted, early_done;
        @(negedge clk);
        if (rst_n === 1'b1 && tx0 === 1'b0) begin
            mon_starts++;
            steady = 1; aborted = 0; early_done = 0; bits = '0;
            for (int b = 0; b < 10 && !aborted; b++) begin
                for (int c = 0; c < 4 && !aborted; c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    if (rst_n !== 1'b1) aborted = 1;
                    else begin
                        if (c == 0) bits[b] = tx0;
                        else if (tx0 !== bits[b]) steady = 0;
                        if (done0 !== 1'b0) early_done = 1;
                    end
                end
            end
            if (aborted) begin
                if (exp_q.size() > 0) exp_q.delete(0);
            end else begin
                @(negedge clk);
                n_cmp++;
                if (done0 !== 1'b1 || ready0 !== 1'b1) begin
                    n_err++;
                    $display("FAIL rx_end_of_frame: done=%b ready=%b, required done=1 ready=1", done0, ready0);
                end
                n_cmp++;
                if (!steady || early_done) begin
                    n_err++;
                    $display("FAIL rx_bit_shape: steady=%0d early_done=%0d, required steady=1 early_done=0", steady, early_done);
                end
                n_cmp++;
                if (bits[0] !== 1'b0 || bits[9] !== 1'b1) begin
                    n_err++;
                    $display("FAIL rx_framing: start=%b stop=%b, required start=0 stop=1", bits[0], bits[9]);
                end
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rx_unexpected_frame: got %h, required no frame", bits[8:1]);
                end else begin
                    want = exp_q.pop_front();
                    if (bits[8:1] !== want) begin
                        n_err++;
                        $display("FAIL rx_word: got %h, required %h", bits[8:1], want);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        bit bad = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({tx0, ready0, done0} !== 3'b110) begin
            n_err++;
            $display("FAIL reset_hold: tx/ready/done=%b, required 110", {tx0, ready0, done0});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ({tx0, ready0, done0} !== 3'b110) bad = 1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL reset_idle_100: outputs left 110 after reset, now %b", {tx0, ready0, done0});
        end
    endtask

    task automatic test_single();
        int k = 0;
        bit seen = 0;
        @(negedge clk);
        din0 = 8'hA5; start0 = 1'b1; exp_q.push_back(8'hA5);
        while (k < 100 && !seen) begin
            @(negedge clk);
            start0 = 1'b0; k++;
            if (done0 === 1'b1) seen = 1;
        end
        n_cmp++;
        if (!seen || k != 41) begin
            n_err++;
            $display("FAIL single_done_time: seen=%0d at %0d cycles, required 41", seen, k);
        end
        @(negedge clk);
        n_cmp++;
        if (done0 !== 1'b0) begin
            n_err++;
            $display("FAIL single_done_width: done=%b one cycle later, required 0", done0);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL single_received: %0d words pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_parity();
        logic [10:0] exp_e, exp_o, got_e, got_o;
        int k = 0;
        bit seen = 0;
        exp_e = {1'b1, 1'b1, 8'h07, 1'b0};
        exp_o = {1'b1, 1'b0, 8'h07, 1'b0};
        got_e = '0; got_o = '0;
        @(negedge clk);
        dinp = 8'h07; startp = 1'b1;
        while (k < 100 && !seen) begin
            @(negedge clk);
            startp = 1'b0; k++;
            if ((k - 1) % 4 == 1 && (k - 1) / 4 < 11) begin
                got_e[(k - 1) / 4] = tx_pe;
                got_o[(k - 1) / 4] = tx_po;
            end
            if (done_pe === 1'b1) seen = 1;
        end
        n_cmp++;
        if (!seen || k != 45) begin
            n_err++;
            $display("FAIL parity_frame_len: seen=%0d at %0d cycles, required 45", seen, k);
        end
        n_cmp++;
        if (done_po !== 1'b1 || ready_pe !== 1'b1 || ready_po !== 1'b1) begin
            n_err++;
            $display("FAIL parity_done_align: done_po=%b ready_pe=%b ready_po=%b, required 111", done_po, ready_pe, ready_po);
        end
        n_cmp++;
        if (got_e !== exp_e) begin
            n_err++;
            $display("FAIL parity_even_frame: got %b, required %b", got_e, exp_e);
        end
        n_cmp++;
        if (got_o !== exp_o) begin
            n_err++;
            $display("FAIL parity_odd_frame: got %b, required %b", got_o, exp_o);
        end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        bit seen = 0;
        @(negedge clk);
        din0 = 8'h55; start0 = 1'b1; exp_q.push_back(8'h55);
        while (k < 100 && !seen) begin
            @(negedge clk);
            k++;
            if (done0 === 1'b1) seen = 1;
        end
        n_cmp++;
        if (!seen || ready0 !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_first_done: seen=%0d ready=%b, required seen=1 ready=1", seen, ready0);
        end
        din0 = 8'hAA; exp_q.push_back(8'hAA);
        @(negedge clk);
        n_cmp++;
        if (tx0 !== 1'b0 || ready0 !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_next_start: tx=%b ready=%b after done, required tx=0 ready=0", tx0, ready0);
        end
        start0 = 1'b0;
        k = 0; seen = 0;
        while (k < 100 && !seen) begin
            @(negedge clk);
            k++;
            if (done0 === 1'b1) seen = 1;
        end
        @(negedge clk);
        n_cmp++;
        if (!seen || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_both_words: seen=%0d pending=%0d, required seen=1 pending=0", seen, exp_q.size());
        end
    endtask

    task automatic test_busy();
        int k = 0;
        int starts_before;
        bit seen = 0, busy_bad = 0, line_bad = 0;
        @(negedge clk);
        din0 = 8'h3C; start0 = 1'b1; exp_q.push_back(8'h3C);
        repeat (14) begin
            @(negedge clk);
            start0 = 1'b0;
        end
        din0 = 8'hFF; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        while (k < 100 && !seen) begin
            if (done0 === 1'b1) seen = 1;
            else begin
                if (ready0 !== 1'b0) busy_bad = 1;
                @(negedge clk);
                k++;
            end
        end
        n_cmp++;
        if (!seen || busy_bad || ready0 !== 1'b1) begin
            n_err++;
            $display("FAIL busy_ready: seen=%0d busy_ready_high=%0d ready_at_done=%b, required 1/0/1", seen, busy_bad, ready0);
        end
        starts_before = mon_starts;
        repeat (60) begin
            @(negedge clk);
            if (tx0 !== 1'b1) line_bad = 1;
        end
        n_cmp++;
        if (line_bad || mon_starts != starts_before) begin
            n_err++;
            $display("FAIL busy_no_second_frame: line_low=%0d extra_starts=%0d, required 0/0", line_bad, mon_starts - starts_before);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL busy_received: %0d words pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        bit seen = 0;
        @(negedge clk);
        din0 = 8'h50; start0 = 1'b1; exp_q.push_back(8'h50);
        while (k < 18) begin
            @(negedge clk);
            start0 = 1'b0; k++;
        end
        n_cmp++;
        if (tx0 !== 1'b0 || ready0 !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_before: tx=%b ready=%b in data bit 3, required 0/0", tx0, ready0);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({tx0, ready0, done0} !== 3'b110) begin
            n_err++;
            $display("FAIL midreset_async: tx/ready/done=%b, required 110", {tx0, ready0, done0});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        din0 = 8'h81; start0 = 1'b1; exp_q.push_back(8'h81);
        k = 0;
        while (k < 100 && !seen) begin
            @(negedge clk);
            start0 = 1'b0; k++;
            if (done0 === 1'b1) seen = 1;
        end
        @(negedge clk);
        n_cmp++;
        if (!seen || k != 41 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL midreset_next_frame: seen=%0d cycles=%0d pending=%0d, required 1/41/0", seen, k, exp_q.size());
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        start0 = 1'b0; din0 = '0;
        startp = 1'b0; dinp = '0;
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_busy();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
